crp16_alu_result_stage: RTL and testbench

//  Registered stage directly downstream of the CRP16 ALU (crp16_alu).
//  - Captures alu_out plus destination tag into a 2-entry skid buffer with valid/ready handshakes.
//  - Holds the processor status flags (V,C,N,Z) in a flag register.
//  - Evaluates branch conditions against the flag register for the fetch/branch unit.
//  - Feeds the register-file writeback port.

---
 rtl/crp16_alu_result_stage.sv | 152 +++++++++++++++
 tb/tb_crp16_alu_result_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/crp16_alu_result_stage.sv
// crp16_alu_result_stage
// Register stage behind the CRP16 ALU. Results and their destination tags go
// into a 2-entry skid buffer with valid/ready on both sides. The buffer head
// drives the register-file writeback port directly from registers. The stage
// also holds the V/C/N/Z flag register and evaluates branch conditions on it.

module crp16_alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              v,
    input  logic              c,
    input  logic              n,
    input  logic              z,
    input  logic              flag_we,
    input  logic [TAG_W-1:0]  in_dest,
    input  logic              wb_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_dest,
    output logic              out_wb_en,
    output logic [3:0]        flags_q,
    input  logic [2:0]        cond,
    output logic              cond_true
);

    // Each buffered entry is packed as {data, dest, wb_en}
    localparam int ENTRY_W = DATA_W + TAG_W + 1;

    // Buffer occupancy: empty, one entry (head only), or full (head + tail)
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t               state_reg;
    occ_t               state_next;
    logic [ENTRY_W-1:0] head_reg;
    logic [ENTRY_W-1:0] head_next;
    logic [ENTRY_W-1:0] tail_reg;
    logic [ENTRY_W-1:0] tail_next;
    logic [3:0]         flags_reg;
    logic [ENTRY_W-1:0] in_entry;
    logic               push;
    logic               pop;
    logic               flag_commit;

    // Handshake signals come only from registered occupancy, so there is no
    // combinational path from in_valid/out_ready to either ready or valid.
    assign in_ready  = (state_reg != OCC_FULL);
    assign out_valid = (state_reg != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_entry  = {alu_out, in_dest, wb_en};

    assign out_data  = head_reg[ENTRY_W-1 -: DATA_W];
    assign out_dest  = head_reg[TAG_W:1];
    assign out_wb_en = head_reg[0];
    assign flags_q   = flags_reg;

    // A flag write commits when the result is accepted. A flush empties the
    // buffer in the same edge, so any offered flag write is taken then even
    // if the buffer was full; the result itself is discarded.
    assign flag_commit = in_valid & flag_we & (in_ready | flush);

    // Occupancy state and entry registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= OCC_EMPTY;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
        end
    end

    // Next occupancy and entry movement; flush overrides and freezes entries
    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        case (state_reg)
            OCC_EMPTY: begin
                if (push) begin
                    head_next  = in_entry;
                    state_next = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    // Old head leaves, new result takes its place
                    head_next = in_entry;
                end else if (push) begin
                    tail_next  = in_entry;
                    state_next = OCC_FULL;
                end else if (pop) begin
                    // Head register keeps its value while the buffer is empty
                    state_next = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_next  = tail_reg;
                    state_next = OCC_ONE;
                end
            end
            default: begin
                state_next = OCC_EMPTY;
            end
        endcase
        if (flush) begin
            state_next = OCC_EMPTY;
            head_next  = head_reg;
            tail_next  = tail_reg;
        end
    end

    // Flag register {V,C,N,Z}, updated in issue order and unaffected by pops
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flags_reg <= 4'b0000;
        end else if (flag_commit) begin
            flags_reg <= {v, c, n, z};
        end
    end

    // Branch condition decode on the registered flags
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = 1'b1;                            // always
            3'b001:  cond_true = flags_reg[0];                    // EQ
            3'b010:  cond_true = ~flags_reg[0];                   // NE
            3'b011:  cond_true = flags_reg[1] ^ flags_reg[3];     // LT
            3'b100:  cond_true = ~(flags_reg[1] ^ flags_reg[3]);  // GE
            3'b101:  cond_true = ~flags_reg[2];                   // LTU (borrow)
            3'b110:  cond_true = flags_reg[2];                    // GEU
            default: cond_true = 1'b0;                            // never
        endcase
    end

endmodule

// File: tb/tb_crp16_alu_result_stage.sv
// Testbench for crp16_alu_result_stage: directed scenarios followed by random
// traffic, checked by a queue-based scoreboard and a flag/condition model.

module tb_crp16_alu_result_stage;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_out;
    logic        v, c, n, z;
    logic        flag_we;
    logic [2:0]  in_dest;
    logic        wb_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_dest;
    logic        out_wb_en;
    logic [3:0]  flags_q;
    logic [2:0]  cond;
    logic        cond_true;

    int n_cmp = 0;
    int n_err = 0;

    // Expected contents of the buffer in FIFO order: {data, dest, wb_en}
    logic [19:0] exp_q[$];
    logic [3:0]  exp_flags = 4'b0000;

    crp16_alu_result_stage #(.DATA_W(16), .TAG_W(3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_out   (alu_out),
        .v         (v),
        .c         (c),
        .n         (n),
        .z         (z),
        .flag_we   (flag_we),
        .in_dest   (in_dest),
        .wb_en     (wb_en),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_wb_en (out_wb_en),
        .flags_q   (flags_q),
        .cond      (cond),
        .cond_true (cond_true)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Branch condition meaning written straight from the flag definitions
    function automatic logic cond_eval(input logic [3:0] f, input logic [2:0] cs);
        logic fv, fc, fn, fz;
        fv = f[3]; fc = f[2]; fn = f[1]; fz = f[0];
        case (cs)
            3'd0: return 1'b1;
            3'd1: return fz;
            3'd2: return !fz;
            3'd3: return fn != fv;
            3'd4: return fn == fv;
            3'd5: return !fc;
            3'd6: return fc;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor/scoreboard: sampled on the falling edge, models the next rising edge
    always @(negedge clock) begin
        logic        m_ready;
        logic        m_valid;
        logic [19:0] e;
        if (!resetn) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_flags", {28'd0, flags_q}, 32'd0);
            exp_q.delete();
            exp_flags = 4'b0000;
        end else begin
            m_ready = (exp_q.size() != 2);
            m_valid = (exp_q.size() != 0);
            check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("flags_q", {28'd0, flags_q}, {28'd0, exp_flags});
            check("cond_true", {31'd0, cond_true}, {31'd0, cond_eval(exp_flags, cond)});
            check("out_known", {31'd0, $isunknown({out_data, out_dest, out_wb_en})}, 32'd0);
            if (m_valid && out_ready) begin
                e = exp_q.pop_front();
                $display("pop  data=%h dest=%0d wb=%0d", out_data, out_dest, out_wb_en);
                check("out_data", {16'd0, out_data}, {16'd0, e[19:4]});
                check("out_dest", {29'd0, out_dest}, {29'd0, e[3:1]});
                check("out_wb_en", {31'd0, out_wb_en}, {31'd0, e[0]});
            end
            if (in_valid && m_ready && !flush)
                exp_q.push_back({alu_out, in_dest, wb_en});
            if (in_valid && flag_we && (m_ready || flush))
                exp_flags = {v, c, n, z};
            if (flush)
                exp_q.delete();
        end
    end

    // One cycle of stimulus; returns 1 time unit after the rising edge
    task automatic step(input logic iv, input logic [15:0] d, input logic [3:0] f,
                        input logic fwe, input logic orr, input logic fl);
        in_valid  = iv;
        alu_out   = d;
        {v, c, n, z} = f;
        flag_we   = fwe;
        in_dest   = 3'($urandom_range(0, 7));
        wb_en     = 1'($urandom_range(0, 1));
        out_ready = orr;
        flush     = fl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        cond = 3'd0;
        // 1: reset with in_valid asserted
        step(1'b1, 16'hFFFF, 4'hF, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'hFFFF, 4'hF, 1'b1, 1'b1, 1'b0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        resetn = 1'b1;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_flags", {28'd0, flags_q}, 32'd0);

        // 2: streaming with 1-cycle latency
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 16'(i), 4'h0, 1'b0, 1'b1, 1'b0);
            check("stream_data", {16'd0, out_data}, i);
            check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        // 3: backpressure
        step(1'b1, 16'hAAAA, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h5555, 4'h0, 1'b0, 1'b0, 1'b0);
        check("bp_full", {31'd0, in_ready}, 32'd0);
        step(1'b1, 16'h1111, 4'h0, 1'b0, 1'b0, 1'b0);
        check("bp_hold", {16'd0, out_data}, 32'hAAAA);
        step(1'b1, 16'h1111, 4'h0, 1'b0, 1'b1, 1'b0);
        check("bp_second", {16'd0, out_data}, 32'h5555);
        check("bp_ready", {31'd0, in_ready}, 32'd1);
        step(1'b1, 16'h1111, 4'h0, 1'b0, 1'b1, 1'b0);
        check("bp_third", {16'd0, out_data}, 32'h1111);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        // 4: simultaneous push and pop at count 1
        step(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0, 1'b0);
        check("sim_head", {16'd0, out_data}, 32'h1234);
        step(1'b1, 16'hBEEF, 4'h0, 1'b0, 1'b1, 1'b0);
        check("sim_data", {16'd0, out_data}, 32'hBEEF);
        check("sim_valid", {31'd0, out_valid}, 32'd1);
        check("sim_ready", {31'd0, in_ready}, 32'd1);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        // 5: flags follow flag_we only
        step(1'b1, 16'h0042, 4'b0100, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h0043, 4'b0001, 1'b0, 1'b1, 1'b0);
        check("flags_hold", {28'd0, flags_q}, 32'h4);
        cond = 3'b110; #1;
        check("cond_geu", {31'd0, cond_true}, 32'd1);
        cond = 3'b101; #1;
        check("cond_ltu", {31'd0, cond_true}, 32'd0);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        // 6: flush with full buffer and a flag write
        step(1'b1, 16'h0A0A, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0B0B, 4'h0, 1'b0, 1'b0, 1'b0);
        check("fl_full", {31'd0, in_ready}, 32'd0);
        step(1'b1, 16'h0C0C, 4'b0001, 1'b1, 1'b0, 1'b1);
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_flags", {28'd0, flags_q}, 32'h1);
        cond = 3'b001; #1;
        check("fl_eq", {31'd0, cond_true}, 32'd1);

        // Random traffic with an occasional mid-operation reset
        for (int i = 0; i < 600; i++) begin
            cond = 3'($urandom_range(0, 7));
            if (i == 300) resetn = 1'b0;
            if (i == 302) resetn = 1'b1;
            step(1'($urandom_range(0, 9) < 7), 16'($urandom), 4'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0));
        end
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
